// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial stage feeding a serial detector one bit per clk.
// Accepts WIDTH-bit words over valid/ready and emits each word as WIDTH contiguous bits.
// A one-word pending buffer lets back-to-back words stream with no idle bit between them.
// Ports:
//   clk        - system clock, rising edge active
//   rst        - asynchronous active-low reset
//   load_valid - upstream word offered
//   load_data  - word to serialize, sampled on handshake only
//   load_ready - feeder can take a word this cycle (pending buffer empty)
//   dout       - serial data bit (0 when not valid)
//   dout_valid - dout carries a real data bit
//   last       - dout is the final bit of the current word
//   busy       - shifter active or pending word held
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             load_ready_q;
  logic             accept;
  logic             first_bit;
  logic [WIDTH-1:0] shreg_adv;

  // Bit presented on dout always sits at the leading end of the shift register.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
      first_bit = shreg_d[WIDTH-1];
    end else begin
      shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
      first_bit = shreg_d[0];
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    accept      = load_valid && load_ready_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          // Word boundary: pending word has priority; accept cannot coincide with it.
          cnt_d = '0;
          if (pend_full_q) begin
            shreg_d     = pend_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            shreg_d = load_data;
          end else begin
            shreg_d = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          shreg_d = shreg_adv;
          if (accept) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dout_valid_d = (state_d == SHIFT);
    dout_d       = dout_valid_d && first_bit;
    last_d       = dout_valid_d && (cnt_d == CNT_LAST);
    busy_d       = dout_valid_d || pend_full_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      load_ready_q <= !pend_full_d;
    end
  end

  assign load_ready = load_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign last       = last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: one MSB-first and one LSB-first instance share stimulus.
// A queue-of-bits model predicts every output cycle; literal checks pin the streams.
module tb_serial_bit_feeder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;

  logic ready_m, dout_m, dv_m, last_m, busy_m;
  logic ready_l, dout_l, dv_l, last_l, busy_l;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: bits still to be shown (front = bit on dout now).
  bit q_m[$];
  bit q_l[$];
  bit q_last[$];

  // Observed DUT streams, appended only while dout_valid.
  bit log_m[$];
  bit log_l[$];
  bit log_last[$];

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready_m), .dout(dout_m), .dout_valid(dv_m), .last(last_m), .busy(busy_m)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready_l), .dout(dout_l), .dout_valid(dv_l), .last(last_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_ready();
    return q_m.size() <= W;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one bit leaves per edge, an accepted word appends W bits.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_m.delete();
      q_l.delete();
      q_last.delete();
    end else begin
      bit acc;
      acc = load_valid && model_ready();
      if (q_m.size() > 0) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
        void'(q_last.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          q_m.push_back(load_data[W-1-i]);
          q_l.push_back(load_data[i]);
          q_last.push_back(i == W - 1);
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      bit has;
      has = q_m.size() > 0;
      check("dout_msb",   32'(dout_m),  32'(has ? q_m[0] : 1'b0));
      check("dout_lsb",   32'(dout_l),  32'(has ? q_l[0] : 1'b0));
      check("valid_msb",  32'(dv_m),    32'(has));
      check("valid_lsb",  32'(dv_l),    32'(has));
      check("last_msb",   32'(last_m),  32'(has ? q_last[0] : 1'b0));
      check("last_lsb",   32'(last_l),  32'(has ? q_last[0] : 1'b0));
      check("busy_msb",   32'(busy_m),  32'(has));
      check("busy_lsb",   32'(busy_l),  32'(has));
      check("ready_msb",  32'(ready_m), 32'(model_ready()));
      check("ready_lsb",  32'(ready_l), 32'(model_ready()));
      if (dv_m) begin
        log_m.push_back(dout_m);
        log_last.push_back(last_m);
      end
      if (dv_l) log_l.push_back(dout_l);
    end
  end

  function automatic logic [31:0] pack(input int sel, input int start, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      bit b;
      case (sel)
        0:       b = (start + i < log_m.size())    ? log_m[start+i]    : 1'b0;
        1:       b = (start + i < log_l.size())    ? log_l[start+i]    : 1'b0;
        default: b = (start + i < log_last.size()) ? log_last[start+i] : 1'b0;
      endcase
      r = {r[30:0], b};
    end
    return r;
  endfunction

  // Called just after a negedge: hold valid until the model says the next edge accepts.
  task automatic offer(input logic [W-1:0] w);
    int n;
    n = 0;
    load_valid = 1'b1;
    load_data  = w;
    while (!model_ready() && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!model_ready()) begin
      n_tests++;
      n_fail++;
      $display("FAIL offer_timeout: word %0h never accepted", w);
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = W'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"},  32'(dout_m),  32'd0);
    check({tag, "_valid"}, 32'(dv_m),    32'd0);
    check({tag, "_last"},  32'(last_m),  32'd0);
    check({tag, "_busy"},  32'(busy_m),  32'd0);
    check({tag, "_ready"}, 32'(ready_m), 32'd1);
    check({tag, "_validl"}, 32'(dv_l),   32'd0);
  endtask

  initial begin
    int mark;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst0");
    #20 rst = 1'b1;
    @(negedge clk);

    // Single word, both bit orders.
    mark = log_m.size();
    offer(8'b1011_0010);
    repeat (10) @(negedge clk);
    check("single_msb",  pack(0, mark, 8), 32'h0000_00B2);
    check("single_lsb",  pack(1, mark, 8), 32'h0000_004D);
    check("single_last", pack(2, mark, 8), 32'h0000_0001);
    check("single_cnt",  32'(log_m.size() - mark), 32'd8);
    check("single_idle_dout", 32'(dout_m), 32'd0);

    // Back-to-back: second word offered on the first word's final-bit edge.
    mark = log_m.size();
    offer(8'hA5);
    repeat (7) @(negedge clk);
    offer(8'h3C);
    repeat (12) @(negedge clk);
    check("b2b_msb",  pack(0, mark, 16), 32'h0000_A53C);
    check("b2b_last", pack(2, mark, 16), 32'h0000_0101);
    check("b2b_cnt",  32'(log_m.size() - mark), 32'd16);

    // Backpressure: valid held high across three words.
    mark = log_m.size();
    offer(8'hFF);
    offer(8'h00);
    check("bp_ready_low", 32'(ready_m), 32'd0);
    check("bp_busy",      32'(busy_m),  32'd1);
    offer(8'h81);
    repeat (20) @(negedge clk);
    check("bp_msb",  pack(0, mark, 24), 32'h00FF_0081);
    check("bp_last", pack(2, mark, 24), 32'h0001_0101);
    check("bp_cnt",  32'(log_m.size() - mark), 32'd24);

    // Reset mid-word with a pending word held.
    offer(8'hF0);
    offer(8'h55);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    mark = log_m.size();
    offer(8'h01);
    repeat (12) @(negedge clk);
    check("post_rst_msb", pack(0, mark, 8), 32'h0000_0001);
    check("post_rst_lsb", pack(1, mark, 8), 32'h0000_0080);
    check("post_rst_cnt", 32'(log_m.size() - mark), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage directly upstream of the serial sequence detector (mealy); its dout drives the detector's din one bit per clk.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts each word out in WIDTH consecutive cycles.
- A one-word pending buffer allows back-to-back words with no idle bit between them, so the detector sees a continuous stream across word boundaries.

Parameters:
WIDTH, 8, word size in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first; 0 = bit 0 shifted first.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset (rst==0 resets immediately, independent of clk).
load_valid  input  1  upstream word offered.
load_data  input  WIDTH  word to serialize; sampled only on handshake.
load_ready  output  1  feeder can take a word this cycle.
dout  output  1  serial bit to detector din; registered.
dout_valid  output  1  dout carries a real data bit this cycle.
last  output  1  dout is the final bit of the current word.
busy  output  1  shifter active or pending word held.

Behaviour:
- Reset (rst==0): dout=0, dout_valid=0, last=0, busy=0, load_ready=1, state=IDLE, bit counter=0, pending buffer empty.
- Handshake: word accepted on a rising edge where load_valid==1 and load_ready==1. load_data is don't-care otherwise.
- load_ready = !pend_full. It is a direct decode of a register, so there is no combinational path from load_valid.
- States:
  - IDLE: shifter empty.
  - SHIFT: a word is being emitted.
- IDLE + accept: at that edge, load shift register, counter=0, state=SHIFT. dout shows the first bit in the cycle immediately following the edge. Latency from accept edge to first bit is one edge.
- SHIFT:
  - Each edge advances one bit; counter increments.
  - dout_valid=1 for exactly WIDTH cycles per word.
  - last=1 while counter==WIDTH-1.
- Final-bit edge (counter==WIDTH-1), in priority order:
  - pend_full: move pending word into shifter, clear pend_full, stay in SHIFT.
  - else, if accept occurs at this same edge: load new word directly into shifter, stay in SHIFT.
  - else: go to IDLE, dout_valid=0, dout=0.
- Accept while in SHIFT and not on the final-bit edge: word goes to the pending buffer, pend_full=1, load_ready falls the next cycle.
- Simultaneous final-bit edge with pend_full: accept is impossible because load_ready==0; the pending word is not lost or overwritten.
- Outside valid bits, dout is forced to 0 and last to 0.
- busy = (state==SHIFT) || pend_full.
- Bit order:
  - MSB_FIRST=1: emit bits WIDTH-1 down to 0.
  - MSB_FIRST=0: emit bits 0 up to WIDTH-1.
- Counter width: clog2(WIDTH). It never exceeds WIDTH-1 and wraps to 0 on word reload.
- Reset mid-word: all in-flight and pending data is discarded; outputs return to reset values asynchronously; the first edge after rst rises behaves as IDLE.
- Throughput: sustained one bit per cycle, with zero gap cycles between words, whenever upstream keeps load_valid high.

Test Plan:
- Reset check: drive rst=0 mid-clock with random prior activity -> immediately dout=0, dout_valid=0, last=0, busy=0, load_ready=1.
- Single word: WIDTH=8, MSB_FIRST=1, load 8'b1011_0010 -> dout over 8 cycles = 1,0,1,1,0,0,1,0; dout_valid high 8 cycles; last only on the 8th; then IDLE with dout=0.
- Back-to-back: 8'hA5, then 8'h3C offered on the final-bit edge -> 16 contiguous valid bits 10100101 00111100; no gap; last on bits 8 and 16.
- Backpressure: load_valid held high with words 8'hFF, 8'h00, 8'h81 -> second word taken into pending, load_ready=0 until the first word's final-bit edge; third word accepted afterwards; output stream 24 contiguous bits in order.
- Reset mid-word: after 3 bits of 8'hF0 with a pending word held, assert rst=0 -> outputs cleared at once; after release, load 8'h01 -> only 00000001 emitted, no remnant bits.
- LSB-first: MSB_FIRST=0, load 8'b1011_0010 -> dout = 0,1,0,0,1,1,0,1; last on 8th bit.
